// File: rtl/memory_access_unit_pkg.sv
// Shared types and widths for the memory access unit.
package memory_access_unit_pkg;

  localparam int unsigned AddrWidth = 16;
  localparam int unsigned DataWidth = 16;
  localparam int unsigned BusWidth  = 8;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    LOAD_BYTE,
    LOAD_HALFWORD,
    STORE_BYTE,
    STORE_HALFWORD
  } access_kind_e;

  // Priority: load_halfword > load_byte > store_halfword > store_byte.
  // store_byte is the fall-through, so its flag is not needed here.
  function automatic access_kind_e decode_kind(input logic i_lh, input logic i_lb,
                                               input logic i_sh);
    if (i_lh) return LOAD_HALFWORD;
    if (i_lb) return LOAD_BYTE;
    if (i_sh) return STORE_HALFWORD;
    return STORE_BYTE;
  endfunction

  function automatic logic is_halfword(input access_kind_e i_kind);
    return (i_kind == LOAD_HALFWORD) || (i_kind == STORE_HALFWORD);
  endfunction

  function automatic logic is_load(input access_kind_e i_kind);
    return (i_kind == LOAD_BYTE) || (i_kind == LOAD_HALFWORD);
  endfunction

endpackage

// File: rtl/bus_beat_sequencer.sv
// Drives one byte-bus beat while active and captures the byte returned by reads.
module bus_beat_sequencer
  import memory_access_unit_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_beat_active,
  input  logic                 i_beat_write,
  input  logic [AddrWidth-1:0] i_beat_address,
  input  logic [BusWidth-1:0]  i_beat_wdata,
  input  logic                 i_bus_ready,
  input  logic [BusWidth-1:0]  i_bus_read_data,
  output logic                 o_bus_request,
  output logic                 o_bus_write,
  output logic [AddrWidth-1:0] o_bus_address,
  output logic [BusWidth-1:0]  o_bus_write_data,
  output logic                 o_beat_done,
  output logic [BusWidth-1:0]  o_read_byte
);

  logic [BusWidth-1:0] r_read_byte;

  // Request is held for the whole beat; the beat ends on the edge that samples ready.
  always_comb begin
    o_bus_request    = i_beat_active;
    o_bus_write      = i_beat_active & i_beat_write;
    o_bus_address    = i_beat_address;
    o_bus_write_data = i_beat_wdata;
    o_beat_done      = i_beat_active & i_bus_ready;
    o_read_byte      = r_read_byte;
  end

  // Capture the read byte on the completing edge of a read beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_read_byte <= '0;
    end else if (o_beat_done && !i_beat_write) begin
      r_read_byte <= i_bus_read_data;
    end
  end

endmodule

// File: rtl/memory_access_unit.sv
// Turns byte/halfword load/store requests into little-endian byte-bus beats.
module memory_access_unit
  import memory_access_unit_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 memory_access_load_byte,
  input  logic                 memory_access_load_halfword,
  input  logic                 memory_access_store_byte,
  input  logic                 memory_access_store_halfword,
  input  logic [AddrWidth-1:0] target_address,
  input  logic [DataWidth-1:0] target_data,
  output logic [DataWidth-1:0] memory_data,
  output logic                 reset_memory_access,
  output logic                 busy,
  output logic                 request_error,
  output logic                 bus_request,
  output logic                 bus_write,
  output logic [AddrWidth-1:0] bus_address,
  output logic [BusWidth-1:0]  bus_write_data,
  input  logic                 bus_ready,
  input  logic [BusWidth-1:0]  bus_read_data
);

  state_e               r_state;
  state_e               w_state_next;
  access_kind_e         r_kind;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_data;
  logic [BusWidth-1:0]  r_low_byte;
  logic [DataWidth-1:0] r_mem_data;
  logic                 r_error;

  logic                 w_any_req;
  logic                 w_multi_req;
  logic                 w_beat_active;
  logic                 w_beat_done;
  logic [AddrWidth-1:0] w_beat_address;
  logic [BusWidth-1:0]  w_beat_wdata;
  logic [BusWidth-1:0]  w_read_byte;

  // Request decode and per-beat address/data selection (BEAT1 wraps at 0xFFFF).
  always_comb begin
    w_any_req      = memory_access_load_byte | memory_access_load_halfword |
                     memory_access_store_byte | memory_access_store_halfword;
    w_multi_req    = $countones({memory_access_load_byte, memory_access_load_halfword,
                                 memory_access_store_byte, memory_access_store_halfword}) > 1;
    w_beat_active  = (r_state == BEAT0) || (r_state == BEAT1);
    w_beat_address = (r_state == BEAT1) ? r_addr + 16'd1 : r_addr;
    w_beat_wdata   = (r_state == BEAT1) ? r_data[15:8] : r_data[7:0];
  end

  bus_beat_sequencer u_bus_beat_sequencer (
    .clock            (clock),
    .reset            (reset),
    .i_beat_active    (w_beat_active),
    .i_beat_write     (!is_load(r_kind)),
    .i_beat_address   (w_beat_address),
    .i_beat_wdata     (w_beat_wdata),
    .i_bus_ready      (bus_ready),
    .i_bus_read_data  (bus_read_data),
    .o_bus_request    (bus_request),
    .o_bus_write      (bus_write),
    .o_bus_address    (bus_address),
    .o_bus_write_data (bus_write_data),
    .o_beat_done      (w_beat_done),
    .o_read_byte      (w_read_byte)
  );

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_next        = r_state;
    reset_memory_access = 1'b0;
    busy                = (r_state != IDLE);
    memory_data         = r_mem_data;
    request_error       = r_error;
    unique case (r_state)
      IDLE:  if (w_any_req) w_state_next = BEAT0;
      BEAT0: if (w_beat_done) w_state_next = is_halfword(r_kind) ? BEAT1 : DONE;
      BEAT1: if (w_beat_done) w_state_next = DONE;
      DONE: begin
        reset_memory_access = 1'b1;
        w_state_next        = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register, request latch, low-byte buffer and load result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_kind     <= LOAD_BYTE;
      r_addr     <= '0;
      r_data     <= '0;
      r_low_byte <= '0;
      r_mem_data <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_any_req) begin
        r_kind <= decode_kind(memory_access_load_halfword, memory_access_load_byte,
                              memory_access_store_halfword);
        r_addr <= target_address;
        r_data <= target_data;
        if (w_multi_req) r_error <= 1'b1;
      end
      // The capture register still holds the BEAT0 byte on the edge ending BEAT1.
      if (r_state == BEAT1 && w_beat_done) r_low_byte <= w_read_byte;
      if (r_state == DONE) begin
        if (r_kind == LOAD_BYTE)     r_mem_data <= {8'h00, w_read_byte};
        if (r_kind == LOAD_HALFWORD) r_mem_data <= {w_read_byte, r_low_byte};
      end
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized scoreboard bench for memory_access_unit with a byte-memory slave model.
module tb_memory_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lb = 1'b0, lh = 1'b0, sb = 1'b0, sh = 1'b0;
  logic [15:0] target_address = '0;
  logic [15:0] target_data = '0;
  logic [15:0] memory_data;
  logic        reset_memory_access, busy, request_error;
  logic        bus_request, bus_write;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_ready = 1'b0;
  logic [7:0]  bus_read_data = '0;

  memory_access_unit dut (
    .clock                        (clock),
    .reset                        (reset),
    .memory_access_load_byte      (lb),
    .memory_access_load_halfword  (lh),
    .memory_access_store_byte     (sb),
    .memory_access_store_halfword (sh),
    .target_address               (target_address),
    .target_data                  (target_data),
    .memory_data                  (memory_data),
    .reset_memory_access          (reset_memory_access),
    .busy                         (busy),
    .request_error                (request_error),
    .bus_request                  (bus_request),
    .bus_write                    (bus_write),
    .bus_address                  (bus_address),
    .bus_write_data               (bus_write_data),
    .bus_ready                    (bus_ready),
    .bus_read_data                (bus_read_data)
  );

  always #5 clock = ~clock;

  // kind: 0 load byte, 1 load halfword, 2 store byte, 3 store halfword
  typedef struct {
    int          kind;
    int          issue;
    int          lat;
    logic [15:0] prev_md;
    logic [15:0] exp_md;
    logic        exp_err;
  } txn_t;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
  } beat_t;

  txn_t        exp_q[$];
  beat_t       beat_q[$];
  int          wait_q[$];
  logic [7:0]  mem[int];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] md_model = '0;
  logic        err_model = 1'b0;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Bus slave: random wait states from wait_q, checks each completed beat against beat_q.
  int   s_cnt = 0;
  logic s_open = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      s_open    = 1'b0;
      bus_ready = 1'b0;
    end else if (bus_request) begin
      if (!s_open) begin
        s_open = 1'b1;
        s_cnt  = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      end
      if (s_cnt == 0) begin
        beat_t b;
        bus_ready     = 1'b1;
        s_open        = 1'b0;
        bus_read_data = mem_rd(bus_address);
        if (beat_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected beat: got addr %0h expected no beat", bus_address);
        end else begin
          b = beat_q.pop_front();
          check("beat address", 32'(bus_address), 32'(b.addr));
          check("beat write", 32'(bus_write), 32'(b.wr));
          if (b.wr) begin
            check("beat write data", 32'(bus_write_data), 32'(b.data));
            mem[int'(bus_address)] = bus_write_data;
          end
        end
      end else begin
        s_cnt--;
        bus_ready     = 1'b0;
        bus_read_data = 8'($urandom);
      end
    end else begin
      bus_ready     = 1'($urandom_range(0, 1));
      bus_read_data = 8'($urandom);
    end
  end

  // Monitor: pops an expectation on every completion pulse.
  logic pend = 1'b0;
  txn_t pe;
  always @(negedge clock) begin
    if (pend) begin
      pend = 1'b0;
      check("memory_data after done", 32'(memory_data), 32'(pe.exp_md));
      check("request_error", 32'(request_error), 32'(pe.exp_err));
    end
    if (reset_memory_access) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected pulse: got pulse expected none");
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        check("latency", 32'(cyc - t.issue + 1), 32'(t.lat));
        check("memory_data held in done", 32'(memory_data), 32'(t.prev_md));
        check("busy in done", 32'(busy), 32'd1);
        check("bus_request in done", 32'(bus_request), 32'd0);
        pe   = t;
        pend = 1'b1;
      end
    end
  end

  // Issue one request (f = {sh, sb, lh, lb}); called just after a rising edge.
  task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] d,
                       input int w0, input int w1);
    txn_t        t;
    logic [15:0] a1;
    logic        hw, ld;
    int          n;
    a1 = a + 16'd1;
    t.kind = f[1] ? 1 : f[0] ? 0 : f[3] ? 3 : 2;
    hw = (t.kind == 1) || (t.kind == 3);
    ld = (t.kind < 2);
    t.prev_md = md_model;
    if (t.kind == 0) md_model = {8'h00, mem_rd(a)};
    if (t.kind == 1) md_model = {mem_rd(a1), mem_rd(a)};
    t.exp_md = md_model;
    if ($countones(f) > 1) err_model = 1'b1;
    t.exp_err = err_model;
    t.lat = (hw ? 4 : 3) + w0 + (hw ? w1 : 0);
    beat_q.push_back('{addr: a, wr: !ld, data: d[7:0]});
    wait_q.push_back(w0);
    if (hw) begin
      beat_q.push_back('{addr: a1, wr: !ld, data: d[15:8]});
      wait_q.push_back(w1);
    end
    {sh, sb, lh, lb} = f;
    target_address = a;
    target_data    = d;
    t.issue = cyc;
    exp_q.push_back(t);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!reset_memory_access && n < 200);
    if (!reset_memory_access) begin
      n_checks++;
      n_errors++;
      $display("FAIL completion timeout: got no pulse expected pulse within 200 cycles");
      exp_q.delete();
      beat_q.delete();
      wait_q.delete();
    end
    @(posedge clock);
    #1;
    {sh, sb, lh, lb} = 4'b0000;
  endtask

  initial begin
    logic [3:0]  f;
    logic [15:0] a;
    int          n;

    repeat (3) @(posedge clock);
    #1;
    check("reset memory_data", 32'(memory_data), 32'd0);
    check("reset bus_request", 32'(bus_request), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset request_error", 32'(request_error), 32'd0);
    check("reset pulse", 32'(reset_memory_access), 32'd0);
    check("reset bus_address", 32'(bus_address), 32'd0);
    check("reset bus_write_data", 32'(bus_write_data), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Directed cases.
    mem[32'h1234] = 8'hAB;
    issue(4'b0001, 16'h1234, 16'h0000, 0, 0);
    mem[32'hFFFF] = 8'h34;
    mem[32'h0000] = 8'h12;
    issue(4'b0010, 16'hFFFF, 16'h0000, 0, 2);
    issue(4'b1000, 16'h0100, 16'hBEEF, 1, 0);
    issue(4'b0101, 16'h2000, 16'h00C3, 0, 0);

    // Random traffic, with back-to-back requests when the gap is zero.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) f = 4'($urandom_range(1, 15));
      else f = 4'b0001 << $urandom_range(0, 3);
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63));
      issue(f, a, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end

    // Abort a halfword load in BEAT1 with reset.
    beat_q.push_back('{addr: 16'h4000, wr: 1'b0, data: 8'h00});
    wait_q.push_back(0);
    wait_q.push_back(50);
    target_address = 16'h4000;
    lh = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(bus_request && bus_address == 16'h4001) && n < 50);
    check("reached second beat", 32'(bus_address), 32'h4001);
    #2;
    reset = 1'b0;
    #1;
    check("abort bus_request", 32'(bus_request), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort pulse", 32'(reset_memory_access), 32'd0);
    check("abort memory_data", 32'(memory_data), 32'd0);
    check("abort request_error", 32'(request_error), 32'd0);
    lh = 1'b0;
    beat_q.delete();
    wait_q.delete();
    md_model  = '0;
    err_model = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    issue(4'b0001, 16'h0042, 16'h0000, 1, 0);
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
